// File: rtl/prog_mem.sv
// Program memory with power-up/reset clearing, single-cycle fetch port and a
// write port guarded by a sticky lock.
module prog_mem #(
    parameter int unsigned DATA_W = 35,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              lock,
    output logic              load_err,
    output logic              locked
);

    localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              fetch_accept_c;
    logic              fetch_in_range_c;
    logic [IDX_W-1:0]  fetch_idx_c;
    logic              load_in_range_c;
    logic              load_commit_c;
    logic [IDX_W-1:0]  load_idx_c;

    // Address decode and write qualification; locked is the pre-edge value,
    // so a load in the same cycle lock first rises still commits.
    always_comb begin
        fetch_accept_c   = fetch_req && fetch_ready;
        fetch_in_range_c = {1'b0, fetch_addr} < DEPTH_L;
        fetch_idx_c      = IDX_W'(fetch_addr);
        load_in_range_c  = {1'b0, load_addr} < DEPTH_L;
        load_idx_c       = IDX_W'(load_addr);
        load_commit_c    = reset_n && load_en && (state == READY)
                           && !locked && load_in_range_c;
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= CLEAR;
            clr_addr    <= '0;
            fetch_ready <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            load_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            fetch_valid <= fetch_accept_c;
            if (fetch_accept_c) begin
                fetch_data <= fetch_in_range_c ? mem[fetch_idx_c] : '0;
            end
            load_err <= load_en && !load_commit_c;
            if (lock) begin
                locked <= 1'b1;
            end
            if (state == CLEAR) begin
                if (clr_addr == LAST_IDX) begin
                    state       <= READY;
                    fetch_ready <= 1'b1;
                    clr_addr    <= '0;
                end else begin
                    clr_addr <= clr_addr + IDX_W'(1);
                end
            end
        end
    end

    // Storage: the clear sweep owns the write port until READY.
    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (load_commit_c) begin
            mem[load_idx_c] <= load_data;
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
// Directed, table-driven bench for prog_mem: a DEPTH=256 instance for the main
// behaviour and a DEPTH=200 instance for the out-of-range corner cases.
module tb_prog_mem;

    localparam int unsigned DW = 35;
    localparam int unsigned AW = 8;
    localparam logic [DW-1:0] PAT = 35'h1_2345_6789;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n, fetch_req, load_en, lock;
    logic [AW-1:0] fetch_addr, load_addr;
    logic [DW-1:0] load_data;
    logic          fetch_ready, fetch_valid, load_err, locked;
    logic [DW-1:0] fetch_data;

    logic          b_reset_n, b_fetch_req, b_load_en, b_lock;
    logic [AW-1:0] b_fetch_addr, b_load_addr;
    logic [DW-1:0] b_load_data;
    logic          b_fetch_ready, b_fetch_valid, b_load_err, b_locked;
    logic [DW-1:0] b_fetch_data;

    prog_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .lock(lock), .load_err(load_err), .locked(locked)
    );

    prog_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200)) dut_b (
        .clock(clock), .reset_n(b_reset_n),
        .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr),
        .fetch_ready(b_fetch_ready), .fetch_valid(b_fetch_valid), .fetch_data(b_fetch_data),
        .load_en(b_load_en), .load_addr(b_load_addr), .load_data(b_load_data),
        .lock(b_lock), .load_err(b_load_err), .locked(b_locked)
    );

    typedef struct {
        logic          ld;
        logic [AW-1:0] la;
        logic [DW-1:0] ldd;
        logic          fr;
        logic [AW-1:0] fa;
        logic          lk;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          e_err;
        logic          e_locked;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic count_low_a(inout int n);
        while (!fetch_ready && n < 1000) begin
            n++;
            step();
        end
    endtask

    task automatic count_low_b(inout int n);
        while (!b_fetch_ready && n < 1000) begin
            n++;
            step();
        end
    endtask

    task automatic idle_a();
        fetch_req = 1'b0; load_en = 1'b0; lock = 1'b0;
    endtask

    initial begin
        int n;
        int valid_seen;

        vecs[0]  = '{1'b0, 8'd0,  35'h0, 1'b1, 8'd20, 1'b0, 1'b1, 35'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'd4,  PAT,   1'b0, 8'd0,  1'b0, 1'b0, 35'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'd0,  35'h0, 1'b1, 8'd4,  1'b0, 1'b1, PAT,   1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'd0,  35'h0, 1'b1, 8'd4,  1'b0, 1'b1, PAT,   1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'd0,  35'h0, 1'b1, 8'd5,  1'b0, 1'b1, 35'h0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'd0,  35'h0, 1'b1, 8'd4,  1'b0, 1'b1, PAT,   1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'd0,  35'h0, 1'b0, 8'd0,  1'b0, 1'b0, PAT,   1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'd7,  35'h7, 1'b1, 8'd7,  1'b0, 1'b1, 35'h0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'd0,  35'h0, 1'b1, 8'd7,  1'b0, 1'b1, 35'h7, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'd11, 35'h3, 1'b0, 8'd0,  1'b1, 1'b0, 35'h7, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'd0,  35'h0, 1'b1, 8'd11, 1'b0, 1'b1, 35'h3, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 8'd10, 35'h5, 1'b0, 8'd0,  1'b0, 1'b0, 35'h3, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 8'd0,  35'h0, 1'b1, 8'd10, 1'b0, 1'b1, 35'h0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 8'd0,  35'h0, 1'b0, 8'd0,  1'b0, 1'b0, 35'h0, 1'b0, 1'b1};

        reset_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; load_en = 1'b0;
        load_addr = '0; load_data = '0; lock = 1'b0;
        b_reset_n = 1'b0; b_fetch_req = 1'b0; b_fetch_addr = '0; b_load_en = 1'b0;
        b_load_addr = '0; b_load_data = '0; b_lock = 1'b0;

        // Reset values
        step(); step();
        chk("rst_ready", 64'(fetch_ready), 64'd0);
        chk("rst_valid", 64'(fetch_valid), 64'd0);
        chk("rst_data",  64'(fetch_data),  64'd0);
        chk("rst_err",   64'(load_err),    64'd0);
        chk("rst_locked", 64'(locked),     64'd0);

        // Clear sweep with a fetch held pending: must be ignored throughout
        reset_n = 1'b1; fetch_req = 1'b1; fetch_addr = 8'd20;
        n = 0; valid_seen = 0;
        while (!fetch_ready && n < 1000) begin
            n++;
            step();
            if (fetch_valid) valid_seen++;
        end
        chk("clear_cycles", 64'(n), 64'd256);
        chk("clear_no_valid", 64'(valid_seen), 64'd0);

        // Vector table; the first entry is the pending fetch of address 20
        for (int i = 0; i < NV; i++) begin
            load_en = vecs[i].ld; load_addr = vecs[i].la; load_data = vecs[i].ldd;
            fetch_req = vecs[i].fr; fetch_addr = vecs[i].fa; lock = vecs[i].lk;
            step();
            chk($sformatf("v%0d_valid", i),  64'(fetch_valid), 64'(vecs[i].e_valid));
            chk($sformatf("v%0d_data", i),   64'(fetch_data),  64'(vecs[i].e_data));
            chk($sformatf("v%0d_err", i),    64'(load_err),    64'(vecs[i].e_err));
            chk($sformatf("v%0d_locked", i), 64'(locked),      64'(vecs[i].e_locked));
        end
        idle_a();

        // Lock is sticky until reset
        repeat (5) step();
        chk("lock_sticky", 64'(locked), 64'd1);
        reset_n = 1'b0;
        step();
        chk("lock_cleared", 64'(locked), 64'd0);
        reset_n = 1'b1;
        n = 0;
        count_low_a(n);
        chk("reclear_cycles", 64'(n), 64'd256);

        // Write, then reset in READY must wipe it
        load_en = 1'b1; load_addr = 8'd3; load_data = 35'h9;
        step();
        chk("ld3_err", 64'(load_err), 64'd0);
        load_en = 1'b0; fetch_req = 1'b1; fetch_addr = 8'd3;
        step();
        chk("ld3_fetch", 64'(fetch_data), 64'h9);
        // Fetch presented at the reset edge is dropped
        reset_n = 1'b0;
        step();
        chk("drop_valid", 64'(fetch_valid), 64'd0);
        chk("drop_data",  64'(fetch_data),  64'd0);
        chk("drop_ready", 64'(fetch_ready), 64'd0);
        fetch_req = 1'b0; reset_n = 1'b1;
        n = 0;
        count_low_a(n);
        chk("ready_reclear", 64'(n), 64'd256);
        fetch_req = 1'b1; fetch_addr = 8'd3;
        step();
        chk("wiped_valid", 64'(fetch_valid), 64'd1);
        chk("wiped_data",  64'(fetch_data),  64'd0);
        fetch_addr = 8'd7;
        step();
        chk("wiped7_data", 64'(fetch_data), 64'd0);
        fetch_req = 1'b0;

        // Reset when clr_addr reaches 100 restarts the sweep
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (100) step();
        chk("mid_clear_ready", 64'(fetch_ready), 64'd0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1; load_en = 1'b1; load_addr = 8'd3; load_data = 35'h9;
        step();
        chk("clear_load_err", 64'(load_err), 64'd1);
        load_en = 1'b0;
        n = 1;
        count_low_a(n);
        chk("restart_cycles", 64'(n), 64'd256);
        fetch_req = 1'b1; fetch_addr = 8'd3;
        step();
        chk("restart_fetch3", 64'(fetch_data), 64'd0);
        fetch_req = 1'b0;

        // DEPTH=200 instance
        b_reset_n = 1'b1;
        n = 0;
        count_low_b(n);
        chk("b_clear_cycles", 64'(n), 64'd200);
        b_load_en = 1'b1; b_load_addr = 8'd199; b_load_data = 35'h55;
        step();
        chk("b_ld199_err", 64'(b_load_err), 64'd0);
        b_load_en = 1'b0; b_fetch_req = 1'b1; b_fetch_addr = 8'd199;
        step();
        chk("b_f199_data", 64'(b_fetch_data), 64'h55);
        b_fetch_addr = 8'd250;
        step();
        chk("b_f250_valid", 64'(b_fetch_valid), 64'd1);
        chk("b_f250_data",  64'(b_fetch_data),  64'd0);
        b_fetch_req = 1'b0; b_load_en = 1'b1; b_load_addr = 8'd250; b_load_data = 35'h66;
        step();
        chk("b_ld250_err", 64'(b_load_err), 64'd1);
        b_load_en = 1'b0;
        step();
        chk("b_err_pulse", 64'(b_load_err), 64'd0);
        chk("b_hold_data", 64'(b_fetch_data), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
